gray8_rgb565_framer: RTL and testbench

- Converts an 8-bit grey pixel stream into RGB565 for the display/SDRAM write path. It is the inverse-direction companion of the RGB565-to-grey stage.
- Input and output use the team's vld/sop/eop streaming interface.
- A frame state machine with column and row counters checks the incoming frame structure. Output sop/eop are regenerated from the counters, so downstream always sees exactly COLS*ROWS pixels per frame, and protocol violations are flagged.

---
 rtl/gray8_rgb565_framer.sv | 127 ++++++++++++
 tb/tb_gray8_rgb565_framer.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/gray8_rgb565_framer.sv
// Grey-to-RGB565 stream converter with frame-structure checking.
// Output sop/eop come from the internal column/row counters, so every frame leaves with exactly COLS*ROWS pixels.
module gray8_rgb565_framer #(
  parameter int COLS = 640,
  parameter int ROWS = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  din,
  input  logic        din_vld,
  input  logic        din_sop,
  input  logic        din_eop,
  output logic [15:0] dout,
  output logic        dout_vld,
  output logic        dout_sop,
  output logic        dout_eop,
  output logic        frame_err,
  output logic [15:0] frame_cnt
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam bit SINGLE = (COLS * ROWS == 1);

  // Counter position after the first pixel of a frame has been accepted.
  localparam logic [CW-1:0] FIRST_COL = (COLS == 1) ? '0 : CW'(1);
  localparam logic [RW-1:0] FIRST_ROW = (COLS == 1) ? RW'(1) : '0;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_col, w_col_nxt;
  logic [RW-1:0] r_row, w_row_nxt;
  logic          w_last, w_vld, w_sop, w_eop, w_err, w_done;

  assign w_last = (r_col == CW'(COLS - 1)) && (r_row == RW'(ROWS - 1));

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_state_nxt = r_state;
    w_col_nxt   = r_col;
    w_row_nxt   = r_row;
    w_vld       = 1'b0;
    w_sop       = 1'b0;
    w_eop       = 1'b0;
    w_err       = 1'b0;
    w_done      = 1'b0;
    if (din_vld) begin
      case (r_state)
        IDLE: begin
          if (din_sop) begin
            w_vld = 1'b1;
            w_sop = 1'b1;
            if (SINGLE) begin
              w_eop  = 1'b1;
              w_done = din_eop;
              w_err  = !din_eop;
            end else if (din_eop) begin
              w_eop = 1'b1;
              w_err = 1'b1;
            end else begin
              w_col_nxt   = FIRST_COL;
              w_row_nxt   = FIRST_ROW;
              w_state_nxt = ACTIVE;
            end
          end
        end
        ACTIVE: begin
          w_vld = 1'b1;
          if (din_sop) begin
            // Restart: abandon the current frame, this pixel opens a new one.
            w_sop = 1'b1;
            w_err = 1'b1;
            if (din_eop) begin
              w_eop       = 1'b1;
              w_col_nxt   = '0;
              w_row_nxt   = '0;
              w_state_nxt = IDLE;
            end else begin
              w_col_nxt = FIRST_COL;
              w_row_nxt = FIRST_ROW;
            end
          end else if (w_last || din_eop) begin
            w_eop       = 1'b1;
            w_done      = w_last && din_eop;
            w_err       = !(w_last && din_eop);
            w_col_nxt   = '0;
            w_row_nxt   = '0;
            w_state_nxt = IDLE;
          end else if (r_col == CW'(COLS - 1)) begin
            w_col_nxt = '0;
            w_row_nxt = r_row + RW'(1);
          end else begin
            w_col_nxt = r_col + CW'(1);
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_col     <= '0;
      r_row     <= '0;
      dout      <= '0;
      dout_vld  <= 1'b0;
      dout_sop  <= 1'b0;
      dout_eop  <= 1'b0;
      frame_err <= 1'b0;
      frame_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_col     <= w_col_nxt;
      r_row     <= w_row_nxt;
      dout_vld  <= w_vld;
      dout_sop  <= w_sop;
      dout_eop  <= w_eop;
      frame_err <= w_err;
      if (w_vld) dout <= {din[7:3], din[7:2], din[7:3]};
      if (w_done) frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_gray8_rgb565_framer.sv
// Directed bench for gray8_rgb565_framer with a 4x2 frame geometry.
module tb_gray8_rgb565_framer;

  localparam int COLS = 4;
  localparam int ROWS = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  din;
  logic        din_vld, din_sop, din_eop;
  logic [15:0] dout;
  logic        dout_vld, dout_sop, dout_eop, frame_err;
  logic [15:0] frame_cnt;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] last_dout;

  gray8_rgb565_framer #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .din_sop(din_sop),
    .din_eop(din_eop), .dout(dout), .dout_vld(dout_vld), .dout_sop(dout_sop),
    .dout_eop(dout_eop), .frame_err(frame_err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] rgb(input logic [7:0] g);
    return {g[7:3], g[7:2], g[7:3]};
  endfunction

  // Drive one input cycle, then check the output it produces one cycle later.
  task automatic pix(input logic v, input logic s, input logic e, input logic [7:0] d,
                     input logic xv, input logic xs, input logic xe, input logic xr);
    @(negedge clk);
    din_vld = v; din_sop = s; din_eop = e; din = d;
    @(posedge clk);
    #1;
    din_vld = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
    check("dout_vld", dout_vld, xv);
    check("dout_sop", dout_sop, xs);
    check("dout_eop", dout_eop, xe);
    check("frame_err", frame_err, xr);
    if (xv) last_dout = rgb(d);
    check("dout", dout, last_dout);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_dout = '0;
  endtask

  task automatic clean_frame(input bit gaps);
    for (int i = 0; i < COLS * ROWS; i++) begin
      pix(1'b1, i == 0, i == 7, 8'(i * 16), 1'b1, i == 0, i == 7, 1'b0);
      if (gaps) pix(1'b0, 1'b1, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1; din = '0; din_vld = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
    last_dout = '0;
    #1;
    check("rst_dout", dout, 16'h0000);
    check("rst_vld", dout_vld, 1'b0);
    check("rst_cnt", frame_cnt, 16'd0);
    @(negedge clk);
    rst = 1'b0;

    // Clean frame
    clean_frame(1'b0);
    check("clean_last_dout", dout, 16'h738E);
    check("clean_cnt", frame_cnt, 16'd1);

    // Idle drop then a gapped frame
    do_reset();
    for (int i = 0; i < 3; i++) pix(1'b1, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    clean_frame(1'b1);
    check("gap_cnt", frame_cnt, 16'd1);

    // sop+eop in IDLE, early eop, then clean
    do_reset();
    pix(1'b1, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b1);
    check("ff_dout", dout, 16'hFFFF);
    check("sop_eop_cnt", frame_cnt, 16'd0);
    for (int i = 0; i < 5; i++) begin
      pix(1'b1, i == 0, i == 4, (i == 0) ? 8'h80 : 8'(i * 16), 1'b1, i == 0, i == 4, i == 4);
      if (i == 0) check("80_dout", dout, 16'h8410);
    end
    clean_frame(1'b0);
    check("early_cnt", frame_cnt, 16'd1);

    // Missing eop, clean frame, then sop on the last pixel
    do_reset();
    for (int i = 0; i < 8; i++)
      pix(1'b1, i == 0, 1'b0, 8'(i * 16 + 8), 1'b1, i == 0, i == 7, i == 7);
    clean_frame(1'b0);
    check("missing_cnt", frame_cnt, 16'd1);
    for (int i = 0; i < 8; i++)
      pix(1'b1, (i == 0) || (i == 7), 1'b0, 8'(i * 32), 1'b1, (i == 0) || (i == 7), 1'b0, i == 7);
    for (int i = 1; i < 8; i++)
      pix(1'b1, 1'b0, i == 7, 8'(i * 32 + 1), 1'b1, 1'b0, i == 7, 1'b0);
    check("lastsop_cnt", frame_cnt, 16'd2);

    // Unexpected sop inside a frame
    do_reset();
    for (int i = 0; i < 11; i++)
      pix(1'b1, (i == 0) || (i == 3), i == 10, 8'(i * 8 + 3), 1'b1, (i == 0) || (i == 3), i == 10, i == 3);
    check("usop_cnt", frame_cnt, 16'd1);

    // Asynchronous reset mid-frame
    do_reset();
    clean_frame(1'b0);
    for (int i = 0; i < 3; i++)
      pix(1'b1, i == 0, 1'b0, 8'(i * 16 + 16), 1'b1, i == 0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_dout", dout, 16'h0000);
    check("arst_vld", dout_vld, 1'b0);
    check("arst_sop", dout_sop, 1'b0);
    check("arst_cnt", frame_cnt, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    last_dout = '0;
    clean_frame(1'b0);
    check("arst_after_cnt", frame_cnt, 16'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
